mdu_ex: RTL and testbench

MDU_EX -- requirements
Module: mduex

---
 rtl/mdu_ex.sv | 88 ++++++++
 tb/tb_mdu_ex.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ex.sv
// mdu_ex: RV32M execute unit with a one-cycle multiply and a 32-cycle radix-2 restoring divide.
// Divide-by-zero and signed overflow skip the divider and complete through the one-cycle MUL slot.
module mdu_ex (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [2:0]  funct3e,
  input  logic [31:0] rd1e,
  input  logic [31:0] rd2e,
  input  logic [4:0]  rde,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rdm
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_q, r_r, r_result;
  logic [4:0]  r_rd, r_rdm, r_cnt;
  logic        w_accept, w_sgn_in, w_spec_in, w_sgn, w_qbit;
  logic [31:0] w_amag_in, w_bmag, w_rn, w_qn, w_quo, w_rem, w_spec, w_fin;
  logic [32:0] w_sh, w_diff;
  logic [63:0] w_ax, w_bx, w_prod;
  assign w_accept  = rstn && r_state == S_IDLE && start && !flush;
  assign w_sgn_in  = !funct3e[0];
  assign w_spec_in = rd2e == 32'h0 || (w_sgn_in && rd1e == 32'h8000_0000 && rd2e == 32'hFFFF_FFFF);
  assign w_amag_in = (w_sgn_in && rd1e[31]) ? -rd1e : rd1e;
  assign w_sgn     = !r_op[0];
  assign w_bmag    = (w_sgn && r_b[31]) ? -r_b : r_b;
  assign w_sh      = {r_r, r_q[31]};
  assign w_diff    = w_sh - {1'b0, w_bmag};
  assign w_qbit    = !w_diff[32];
  assign w_rn      = w_qbit ? w_diff[31:0] : w_sh[31:0];
  assign w_qn      = {r_q[30:0], w_qbit};
  assign w_quo     = (w_sgn && (r_a[31] ^ r_b[31])) ? -w_qn : w_qn;
  assign w_rem     = (w_sgn && r_a[31]) ? -w_rn : w_rn;
  assign w_spec    = r_b == 32'h0 ? (r_op[1] ? r_a : 32'hFFFF_FFFF) : (r_op[1] ? 32'h0 : 32'h8000_0000);
  assign w_ax      = {{32{r_op[1:0] != 2'b11 && r_a[31]}}, r_a};
  assign w_bx      = {{32{!r_op[1] && r_b[31]}}, r_b};
  assign w_prod    = w_ax * w_bx;
  assign w_fin     = r_op[2] ? w_spec : (r_op[1:0] == 2'b00 ? w_prod[31:0] : w_prod[63:32]);
  assign busy      = w_accept || r_state == S_MUL || r_state == S_DIV;
  assign done      = r_state == S_DONE;
  assign result    = r_result;
  assign rdm       = r_rdm;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_q      <= 32'h0;
      r_r      <= 32'h0;
      r_result <= 32'h0;
      r_rd     <= 5'd0;
      r_rdm    <= 5'd0;
      r_cnt    <= 5'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_op    <= funct3e;
      r_a     <= rd1e;
      r_b     <= rd2e;
      r_rd    <= rde;
      r_q     <= w_amag_in;
      r_r     <= 32'h0;
      r_cnt   <= 5'd31;
      r_state <= (funct3e[2] && !w_spec_in) ? S_DIV : S_MUL;
    end else if (r_state == S_MUL) begin
      r_result <= w_fin;
      r_rdm    <= r_rd;
      r_state  <= S_DONE;
    end else if (r_state == S_DIV) begin
      r_q   <= w_qn;
      r_r   <= w_rn;
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd0) begin
        r_result <= r_op[1] ? w_rem : w_quo;
        r_rdm    <= r_rd;
        r_state  <= S_DONE;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: directed vectors for mdu_ex, checked every cycle against a latency/arithmetic reference model.
module tb_mdu_ex;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3e = 3'd0;
  logic [31:0] rd1e = 32'h0, rd2e = 32'h0;
  logic [4:0]  rde = 5'd0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rdm;
  int checks = 0, failures = 0;
  int cyc = 0, m_done_at = 0;
  bit m_pend = 1'b0, chk_on = 1'b0;
  logic [31:0] m_res = 32'h0, m_last_res = 32'h0, saved;
  logic [4:0]  m_rd = 5'd0, m_last_rd = 5'd0;
  always #5 clk = ~clk;
  mdu_ex dut (
    .clk(clk), .rstn(rstn), .start(start), .funct3e(funct3e), .rd1e(rd1e), .rd2e(rd2e),
    .rde(rde), .flush(flush), .busy(busy), .done(done), .result(result), .rdm(rdm)
  );
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2] || b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 33;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rstn) begin
      m_pend = 1'b0;
      m_last_res = 32'h0;
      m_last_rd = 5'd0;
    end else begin
      if (flush) m_pend = 1'b0;
      else if (!m_pend && start) begin
        m_pend = 1'b1;
        m_done_at = cyc + ref_lat(funct3e, rd1e, rd2e) - 1;
        m_res = ref_res(funct3e, rd1e, rd2e);
        m_rd = rde;
      end else if (m_pend && cyc - 1 == m_done_at) m_pend = 1'b0;
      if (!flush && m_pend && cyc == m_done_at) begin
        m_last_res = m_res;
        m_last_rd = m_rd;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy", 32'(busy), 32'(rstn && ((m_pend && cyc < m_done_at) || (!m_pend && start && !flush))));
      chk("cyc_done", 32'(done), 32'(rstn && m_pend && cyc == m_done_at));
      chk("cyc_result", result, rstn ? m_last_res : 32'h0);
      chk("cyc_rdm", 32'(rdm), 32'(rstn ? m_last_rd : 5'd0));
    end
  end
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit, input int lat);
    int got = -1;
    funct3e = f; rd1e = a; rd2e = b; rde = rd; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin got = k; break; end
      nxt;
      if (k == 0) begin
        start = 1'b0; rd1e = $urandom; rd2e = $urandom; funct3e = 3'($urandom); rde = 5'($urandom);
      end
    end
    chk({nm, "_lat"}, 32'(got), 32'(lat));
    chk({nm, "_res"}, result, lit);
    chk({nm, "_rdm"}, 32'(rdm), 32'(rd));
    nxt;
  endtask
  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    funct3e = 3'd5; rd1e = a; rd2e = b; rde = rd; start = 1'b1;
    nxt;
    start = 1'b0;
  endtask
  initial begin
    int n;
    #7;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_rdm", 32'(rdm), 32'h0);
    chk_on = 1'b1;
    nxt; nxt;
    rstn = 1'b1;
    nxt;
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 2);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0, 2);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 2);
    run_op("div", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd9, 32'hFFFF_FFFA, 33);
    run_op("rem", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd10, 32'hFFFF_FFFE, 33);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 33);
    run_op("div_neg_b", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 33);
    run_op("rem_neg_b", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'd1, 33);
    run_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0, 33);
    run_op("remu_big", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 33);
    run_op("divu_z", 3'd5, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, 2);
    run_op("rem_z", 3'd6, 32'd5, 32'd0, 5'd18, 32'd5, 2);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 2);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0, 2);
    saved = result;
    start_div(32'd1000, 32'd3, 5'd21);
    repeat (9) nxt;
    flush = 1'b1;
    nxt;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_result", result, saved);
    n = 0;
    repeat (35) begin @(negedge clk); if (done) n++; end
    chk("flush_nodone", 32'(n), 32'h0);
    nxt;
    start_div(32'd1000, 32'd3, 5'd22);
    repeat (9) nxt;
    flush = 1'b1;
    nxt;
    flush = 1'b0;
    run_op("mul_after_flush", 3'd0, 32'd6, 32'd7, 5'd3, 32'd42, 2);
    saved = result;
    start_div(32'd1000, 32'd3, 5'd23);
    repeat (31) nxt;
    flush = 1'b1;
    nxt;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_last_done", 32'(done), 32'h0);
    chk("flush_last_result", result, saved);
    nxt;
    funct3e = 3'd0; rd1e = 32'd3; rd2e = 32'd4; rde = 5'd1; start = 1'b1;
    nxt; nxt;
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'h1);
    chk("b2b_res1", result, 32'd12);
    nxt;
    rd1e = 32'd10; rd2e = 32'd10; rde = 5'd2;
    @(negedge clk);
    chk("b2b_busy2", 32'(busy), 32'h1);
    nxt;
    start = 1'b0;
    nxt;
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'h1);
    chk("b2b_res2", result, 32'd100);
    chk("b2b_rdm2", 32'(rdm), 32'd2);
    nxt;
    start_div(32'd1000, 32'd7, 5'd24);
    repeat (4) nxt;
    #1 rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_result", result, 32'h0);
    chk("arst_rdm", 32'(rdm), 32'h0);
    nxt; nxt;
    rstn = 1'b1;
    n = 0;
    repeat (35) begin @(negedge clk); if (done) n++; end
    chk("arst_nodone", 32'(n), 32'h0);
    nxt;
    run_op("mul_after_rst", 3'd3, 32'h0001_0000, 32'h0001_0000, 5'd25, 32'h1, 2);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
